// File: rtl/condicionador_pkg.sv
// ============================================================================
// Module   : condicionador_pkg
// Purpose  : Shared types and constants for the drone button conditioner:
//            channel state encoding, axis command codes and a width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package condicionador_pkg;

   // Per-button debounce channel states
   typedef enum logic [1:0] {
      ESPERA       = 2'd0,
      FILTRA_PRESS = 2'd1,
      PRESSIONADO  = 2'd2,
      FILTRA_SOLTA = 2'd3
   } estado_canal_t;

   // Axis command codes as consumed by simulador_drone
   localparam logic [1:0] CMD_NENHUM = 2'b00;
   localparam logic [1:0] CMD_POS    = 2'b01;
   localparam logic [1:0] CMD_NEG    = 2'b10;

   // Largest of three values, used to size the shared counters
   function automatic int maximo3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/botao_debounce.sv
// ============================================================================
// Module   : botao_debounce
// Purpose  : One button channel: 2-FF synchronizer, debounce FSM producing a
//            single-cycle press pulse and a debounced level, plus optional
//            auto-repeat while held (macro CONDICIONADOR_AUTO_REPEAT_EN,
//            active only when REPEAT_ALLOWED = 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module botao_debounce
   import condicionador_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 250,
   parameter int REPEAT_PERIOD   = 100,
   parameter bit REPEAT_ALLOWED  = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic botao,
   output logic pulso,
   output logic nivel
);

   // A channel that never repeats only needs room for the debounce count
   localparam int CW = $clog2(maximo3(DEBOUNCE_CYCLES,
                                      REPEAT_ALLOWED ? REPEAT_DELAY  : 1,
                                      REPEAT_ALLOWED ? REPEAT_PERIOD : 1)) + 1;
   localparam logic [CW-1:0] C_DB_ULTIMO = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] C_CNT_MAX   = '1;

   logic [1:0]      sync_q, sync_d;
   estado_canal_t   estado_q, estado_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   cnt_inc;
   logic            amostra;
   logic            aceite;

   assign amostra = sync_q[1];
   assign sync_d  = {sync_q[0], botao};

   // Synchronizer, FSM state and debounce counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q   <= '0;
         estado_q <= ESPERA;
         cnt_q    <= '0;
      end else begin
         sync_q   <= sync_d;
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
      end
   end

   // Debounce next-state: a level change is accepted after DEBOUNCE_CYCLES
   // consecutive equal samples; the sample that leaves a stable state counts
   // as the first one, so the counter holds (samples seen - 1).
   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      aceite   = 1'b0;
      cnt_inc  = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      case (estado_q)
         ESPERA: begin
            if (amostra) begin
               cnt_d = '0;
               if (DEBOUNCE_CYCLES <= 1) begin
                  estado_d = PRESSIONADO;
                  aceite   = 1'b1;
               end else begin
                  estado_d = FILTRA_PRESS;
               end
            end
         end
         FILTRA_PRESS: begin
            if (!amostra) begin
               estado_d = ESPERA;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= C_DB_ULTIMO) begin
                  estado_d = PRESSIONADO;
                  aceite   = 1'b1;
               end
            end
         end
         PRESSIONADO: begin
            if (!amostra) begin
               cnt_d    = '0;
               estado_d = (DEBOUNCE_CYCLES <= 1) ? ESPERA : FILTRA_SOLTA;
            end
         end
         FILTRA_SOLTA: begin
            if (amostra) begin
               estado_d = PRESSIONADO;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= C_DB_ULTIMO) begin
                  estado_d = ESPERA;
               end
            end
         end
         default: begin
            estado_d = ESPERA;
            cnt_d    = '0;
         end
      endcase
   end

   assign nivel = (estado_q == PRESSIONADO) || (estado_q == FILTRA_SOLTA);

`ifdef CONDICIONADOR_AUTO_REPEAT_EN
   localparam logic [CW-1:0] C_ATRASO  = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] C_PERIODO = CW'(REPEAT_PERIOD);

   logic [CW-1:0] rpt_q, rpt_d;
   logic [CW-1:0] rpt_inc;
   logic [CW-1:0] alvo;
   logic          feito_q, feito_d;
   logic          repete;

   // Repeat counter and first-repeat-done flag registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rpt_q   <= '0;
         feito_q <= 1'b0;
      end else begin
         rpt_q   <= rpt_d;
         feito_q <= feito_d;
      end
   end

   // Repeat timing: runs in PRESSIONADO, frozen in FILTRA_SOLTA, cleared
   // otherwise; first target is the initial delay, then the period.
   always_comb begin
      rpt_d   = rpt_q;
      feito_d = feito_q;
      repete  = 1'b0;
      rpt_inc = (rpt_q == C_CNT_MAX) ? rpt_q : rpt_q + 1'b1;
      alvo    = feito_q ? C_PERIODO : C_ATRASO;
      if (REPEAT_ALLOWED) begin
         case (estado_q)
            PRESSIONADO: begin
               if (rpt_inc >= alvo) begin
                  repete  = 1'b1;
                  rpt_d   = '0;
                  feito_d = 1'b1;
               end else begin
                  rpt_d = rpt_inc;
               end
            end
            FILTRA_SOLTA: begin
               rpt_d = rpt_q;
            end
            default: begin
               rpt_d   = '0;
               feito_d = 1'b0;
            end
         endcase
      end
   end

   assign pulso = aceite | repete;
`else
   assign pulso = aceite;
`endif

endmodule

`default_nettype wire

// File: rtl/condicionador_controles_drone.sv
// ============================================================================
// Module   : condicionador_controles_drone
// Purpose  : Conditions five raw push-buttons into registered single-cycle
//            axis/confirm command pulses for simulador_drone. Opposing pulses
//            on the same axis in the same cycle cancel to CMD_NENHUM.
//            Optional auto-repeat on direction buttons: macro
//            CONDICIONADOR_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module condicionador_controles_drone
   import condicionador_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 250,
   parameter int REPEAT_PERIOD   = 100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       botao_cima,
   input  logic       botao_baixo,
   input  logic       botao_frente,
   input  logic       botao_tras,
   input  logic       botao_confirma,
   output logic [1:0] controle_vertical,
   output logic [1:0] controle_horizontal,
   output logic       confirma,
   output logic [4:0] db_estado_botoes
);

   logic [4:0] botoes;
   logic [4:0] pulsos;
   logic [4:0] niveis;
   logic [1:0] vertical_q, vertical_d;
   logic [1:0] horizontal_q, horizontal_d;
   logic       confirma_q, confirma_d;

   // Bit order {confirma, tras, frente, baixo, cima}
   assign botoes = {botao_confirma, botao_tras, botao_frente, botao_baixo, botao_cima};

   generate
      for (genvar i = 0; i < 5; i++) begin : g_canal
         botao_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_ALLOWED  (i != 4)
         ) u_canal (
            .clock (clock),
            .reset (reset),
            .botao (botoes[i]),
            .pulso (pulsos[i]),
            .nivel (niveis[i])
         );
      end
   endgenerate

   // Axis encoding with cancellation of simultaneous opposing pulses
   always_comb begin
      vertical_d   = CMD_NENHUM;
      horizontal_d = CMD_NENHUM;
      confirma_d   = pulsos[4];
      if (pulsos[0] && !pulsos[1]) vertical_d = CMD_POS;
      else if (pulsos[1] && !pulsos[0]) vertical_d = CMD_NEG;
      if (pulsos[2] && !pulsos[3]) horizontal_d = CMD_POS;
      else if (pulsos[3] && !pulsos[2]) horizontal_d = CMD_NEG;
   end

   // Output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vertical_q   <= CMD_NENHUM;
         horizontal_q <= CMD_NENHUM;
         confirma_q   <= 1'b0;
      end else begin
         vertical_q   <= vertical_d;
         horizontal_q <= horizontal_d;
         confirma_q   <= confirma_d;
      end
   end

   assign controle_vertical   = vertical_q;
   assign controle_horizontal = horizontal_q;
   assign confirma            = confirma_q;
   assign db_estado_botoes    = niveis;

endmodule

`default_nettype wire

// File: tb/tb_condicionador_controles_drone.sv
// ============================================================================
// Module   : tb_condicionador_controles_drone
// Purpose  : Self-checking bench for condicionador_controles_drone with a
//            cycle-level reference model, a vector table and directed
//            corner-case sequences. Repeat expectations follow the macro
//            CONDICIONADOR_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_condicionador_controles_drone;

   localparam int D  = 4;
   localparam int RD = 250;
   localparam int RP = 100;

   logic       clock;
   logic       reset;
   logic [4:0] botoes;
   logic [1:0] controle_vertical;
   logic [1:0] controle_horizontal;
   logic       confirma;
   logic [4:0] db_estado_botoes;

   int n_checks;
   int n_err;

   // Reference model state: sync pipeline, accepted level, run length of
   // samples differing from the level, and hold time for repeats.
   int m_s1[5], m_s2[5], m_lvl[5], m_run[5], m_tempo[5], m_feito[5];
   logic [1:0] exp_v, exp_h;
   logic       exp_c;
   logic [4:0] exp_db;

   // Pulse counters observed since the last clear
   int n_v01, n_v10, n_h01, n_h10, n_c;

   typedef struct {
      logic [4:0] botoes;
      int         ciclos;
      int         v01, v10, h01, h10, c;
      logic [4:0] db;
   } vetor_t;

   vetor_t tab[10];

   condicionador_controles_drone #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .botao_cima          (botoes[0]),
      .botao_baixo         (botoes[1]),
      .botao_frente        (botoes[2]),
      .botao_tras          (botoes[3]),
      .botao_confirma      (botoes[4]),
      .controle_vertical   (controle_vertical),
      .controle_horizontal (controle_horizontal),
      .confirma            (confirma),
      .db_estado_botoes    (db_estado_botoes)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_checks++;
      if (atual !== esperado) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
      end
   endtask

   // Advances the model by one clock edge using the inputs present before it
   task automatic modelo_passo(input logic [4:0] raw, input logic rst_n);
      logic [4:0] p;
      int amostra;
      p = '0;
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
            m_tempo[i] = 0; m_feito[i] = 0;
         end
      end else begin
         for (int i = 0; i < 5; i++) begin
            amostra = m_s2[i];
`ifdef CONDICIONADOR_AUTO_REPEAT_EN
            if (i != 4) begin
               if (m_lvl[i] == 1 && m_run[i] == 0) begin
                  m_tempo[i]++;
                  if (m_tempo[i] == (m_feito[i] != 0 ? RP : RD)) begin
                     p[i] = 1'b1;
                     m_tempo[i] = 0;
                     m_feito[i] = 1;
                  end
               end else if (m_lvl[i] == 0) begin
                  m_tempo[i] = 0;
                  m_feito[i] = 0;
               end
            end
`endif
            if (amostra != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == D) begin
                  m_lvl[i] = amostra;
                  m_run[i] = 0;
                  if (amostra == 1) p[i] = 1'b1;
               end
            end else begin
               m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(raw[i]);
         end
      end
      exp_v = (p[0] ^ p[1]) ? {p[1], p[0]} : 2'b00;
      exp_h = (p[2] ^ p[3]) ? {p[3], p[2]} : 2'b00;
      exp_c = p[4];
      for (int i = 0; i < 5; i++) exp_db[i] = (m_lvl[i] != 0);
   endtask

   // One clock: step the model, wait past the edge, compare and count pulses
   task automatic ciclo();
      modelo_passo(botoes, reset);
      @(posedge clock);
      #1;
      verifica("modelo", {23'd0, controle_vertical, controle_horizontal, confirma, db_estado_botoes},
               {23'd0, exp_v, exp_h, exp_c, exp_db});
      if (controle_vertical == 2'b01)   n_v01++;
      if (controle_vertical == 2'b10)   n_v10++;
      if (controle_horizontal == 2'b01) n_h01++;
      if (controle_horizontal == 2'b10) n_h10++;
      if (confirma)                     n_c++;
   endtask

   task automatic zera_contagem();
      n_v01 = 0; n_v10 = 0; n_h01 = 0; n_h10 = 0; n_c = 0;
   endtask

   task automatic solta_tudo();
      botoes = '0;
      repeat (15) ciclo();
   endtask

   initial begin
      int prim;
      int seq[4];
      int rep[$];
      int esperado_rep[$];

      n_checks = 0;
      n_err    = 0;
      botoes   = 5'b11111;
      reset    = 1'b0;
      zera_contagem();

      tab[0] = '{5'b00001, 20, 1, 0, 0, 0, 0, 5'b00001};
      tab[1] = '{5'b00010, 20, 0, 1, 0, 0, 0, 5'b00010};
      tab[2] = '{5'b00100, 20, 0, 0, 1, 0, 0, 5'b00100};
      tab[3] = '{5'b01000, 20, 0, 0, 0, 1, 0, 5'b01000};
      tab[4] = '{5'b10000, 20, 0, 0, 0, 0, 1, 5'b10000};
      tab[5] = '{5'b00011, 20, 0, 0, 0, 0, 0, 5'b00011};
      tab[6] = '{5'b01100, 20, 0, 0, 0, 0, 0, 5'b01100};
      tab[7] = '{5'b10101, 20, 1, 0, 1, 0, 1, 5'b10101};
      tab[8] = '{5'b01010, 20, 0, 1, 0, 1, 0, 5'b01010};
      tab[9] = '{5'b00000, 20, 0, 0, 0, 0, 0, 5'b00000};

      // Reset held with every button pressed: everything stays at zero
      repeat (10) ciclo();
      verifica("reset_saidas", {27'd0, controle_vertical, controle_horizontal, confirma},
               32'd0);
      verifica("reset_db", {27'd0, db_estado_botoes}, 32'd0);

      // Release reset with buttons still held: fresh debounce, one confirm pulse
      reset = 1'b1;
      zera_contagem();
      prim = 0;
      for (int k = 1; k <= 20; k++) begin
         ciclo();
         if (confirma && prim == 0) prim = k;
      end
      verifica("reset_conf_latencia", prim, 6);
      verifica("reset_conf_qtd", n_c, 1);
      verifica("reset_eixos_cancelados", n_v01 + n_v10 + n_h01 + n_h10, 0);
      verifica("reset_db_final", {27'd0, db_estado_botoes}, 32'h1f);
      solta_tudo();

      // Reset release with one button per axis held: all three pulse together
      reset  = 1'b0;
      botoes = 5'b10101;
      repeat (3) ciclo();
      reset = 1'b1;
      repeat (6) ciclo();
      verifica("reset_tres_pulsos", {27'd0, controle_vertical, controle_horizontal, confirma},
               {27'd0, 2'b01, 2'b01, 1'b1});
      repeat (10) ciclo();
      solta_tudo();

      // Vector table: hold a pattern, release, count pulses per output
      for (int t = 0; t < 10; t++) begin
         zera_contagem();
         botoes = tab[t].botoes;
         repeat (tab[t].ciclos) ciclo();
         verifica($sformatf("tab%0d_db", t), {27'd0, db_estado_botoes}, {27'd0, tab[t].db});
         solta_tudo();
         verifica($sformatf("tab%0d_pulsos", t),
                  {n_v01[3:0], n_v10[3:0], n_h01[3:0], n_h10[3:0], n_c[3:0], 12'd0},
                  {tab[t].v01[3:0], tab[t].v10[3:0], tab[t].h01[3:0], tab[t].h10[3:0],
                   tab[t].c[3:0], 12'd0});
      end

      // Clean forward press: pulse six cycles after the edge, none on release
      zera_contagem();
      prim   = 0;
      botoes = 5'b00100;
      for (int k = 1; k <= 20; k++) begin
         ciclo();
         if (controle_horizontal == 2'b01 && prim == 0) prim = k;
      end
      verifica("frente_latencia", prim, 6);
      solta_tudo();
      verifica("frente_qtd", n_h01, 1);

      // Press bounce 1,0,1,0 then held: single pulse after the stable run
      zera_contagem();
      prim = 0;
      seq  = '{1, 0, 1, 0};
      for (int k = 1; k <= 30; k++) begin
         botoes[0] = (k <= 4) ? seq[k-1][0] : 1'b1;
         ciclo();
         if (controle_vertical == 2'b01 && prim == 0) prim = k;
      end
      verifica("quique_latencia", prim, 10);
      verifica("quique_qtd", n_v01, 1);

      // Release bounce 0,1,0: no extra pulse, level returns to zero
      zera_contagem();
      for (int k = 1; k <= 20; k++) begin
         botoes[0] = (k == 2);
         ciclo();
      end
      verifica("quique_solta_qtd", n_v01, 0);
      verifica("quique_solta_db", {31'd0, db_estado_botoes[0]}, 32'd0);

      // Confirm held for 1000 cycles never repeats
      zera_contagem();
      botoes = 5'b10000;
      repeat (1000) ciclo();
      solta_tudo();
      verifica("confirma_longo", n_c, 1);

      // Back held for 600 cycles: repeat schedule depends on the build option
      zera_contagem();
      botoes = 5'b01000;
      for (int k = 1; k <= 600; k++) begin
         ciclo();
         if (controle_horizontal == 2'b10) rep.push_back(k);
      end
      solta_tudo();
      esperado_rep.push_back(6);
`ifdef CONDICIONADOR_AUTO_REPEAT_EN
      esperado_rep.push_back(6 + RD);
      esperado_rep.push_back(6 + RD + RP);
      esperado_rep.push_back(6 + RD + 2 * RP);
      esperado_rep.push_back(6 + RD + 3 * RP);
`endif
      verifica("repete_qtd", rep.size(), esperado_rep.size());
      for (int i = 0; i < esperado_rep.size(); i++) begin
         verifica($sformatf("repete_t%0d", i), (i < rep.size()) ? rep[i] : -1, esperado_rep[i]);
      end

      // Random bouncy activity with occasional asynchronous resets
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 7) == 0) botoes[i] = ~botoes[i];
         end
         reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         ciclo();
      end
      reset = 1'b1;
      solta_tudo();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/condicionador_controles_drone.md
Name: condicionador_controles_drone

Overview:
- Input-conditioning stage directly upstream of simulador_drone.
- Takes five raw, asynchronous, bouncy push-buttons and produces clean, synchronized, single-cycle command pulses.
- Outputs are encoded in the controle_vertical / controle_horizontal / confirma format that simulador_drone consumes.
- One debounce/edge-detect channel per button; optional auto-repeat for held direction buttons.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a level change (min 1).
- REPEAT_DELAY, 250: cycles a direction button must stay accepted-pressed before the first repeat pulse.
- REPEAT_PERIOD, 100: cycles between subsequent repeat pulses (min 1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- botao_cima  in  1  raw up button, active-high, asynchronous.
- botao_baixo  in  1  raw down button, active-high, asynchronous.
- botao_frente  in  1  raw forward button, active-high, asynchronous.
- botao_tras  in  1  raw back button, active-high, asynchronous.
- botao_confirma  in  1  raw confirm button, active-high, asynchronous.
- controle_vertical  out  2  01 = up pulse, 10 = down pulse, 00 = none.
- controle_horizontal  out  2  01 = forward pulse, 10 = back pulse, 00 = none.
- confirma  out  1  single-cycle confirm pulse.
- db_estado_botoes  out  5  debounced levels {confirma, tras, frente, baixo, cima}.

Behaviour:
- Reset is asynchronous and active-low.
  - While reset = 0: all outputs 0, synchronizers 0, all channels in ESPERA, all counters 0.
  - Reset deasserted mid-press: the channel starts from ESPERA and must re-debounce; no pulse is produced during or at the release of reset.
- Synchronizer:
  - Each raw input passes through 2 flip-flops; the channel sees the second FF output.
  - Latency from raw input to first sample: 2 cycles.
- Channel FSM, per button:
  - States: ESPERA, FILTRA_PRESS, PRESSIONADO, FILTRA_SOLTA.
  - ESPERA: sample = 1 -> FILTRA_PRESS, counter cleared to 0.
  - FILTRA_PRESS:
    - Counter increments each cycle the sample = 1.
    - sample = 0 -> back to ESPERA (bounce rejected).
    - Counter reaches DEBOUNCE_CYCLES-1 with sample = 1 -> PRESSIONADO; emit 1-cycle pulse on the transition edge.
  - PRESSIONADO:
    - Debounced level = 1.
    - sample = 0 -> FILTRA_SOLTA with counter cleared.
  - FILTRA_SOLTA:
    - Symmetric to FILTRA_PRESS.
    - sample = 1 -> back to PRESSIONADO, no new pulse.
    - DEBOUNCE_CYCLES stable zeros -> ESPERA; debounced level = 0.
  - Press latency: with a clean press, the pulse is high exactly 2 + DEBOUNCE_CYCLES cycles after the raw rising edge (registered output).
- Output encoding, registered:
  - controle_vertical = {pulse_baixo, pulse_cima}; controle_horizontal = {pulse_tras, pulse_frente}.
  - Simultaneous opposing pulses in the same cycle (cima+baixo, or frente+tras): that axis outputs 00 for that cycle.
  - Both channels keep their state; a later pulse from either channel is output normally.
  - Vertical, horizontal and confirma pulses in the same cycle are all output independently.
  - Every pulse is exactly 1 cycle wide; outputs return to 00 / 0 the next cycle unless a new pulse occurs.
- Counter widths: $clog2 of the maximum of (DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1 bits. Counters saturate and never wrap.

Optional Feature:
- Macro: CONDICIONADOR_AUTO_REPEAT_EN.
- When defined:
  - Direction channels only; confirma never repeats.
  - While in PRESSIONADO, a repeat counter runs.
  - First extra pulse after REPEAT_DELAY cycles in PRESSIONADO.
  - Then one pulse every REPEAT_PERIOD cycles.
  - Entering FILTRA_SOLTA freezes the repeat counter. Returning to PRESSIONADO from a bounce resumes it. Reaching ESPERA clears it.
- When undefined:
  - Exactly one pulse per accepted press; no repeat logic synthesized.

Decomposition:
- Package condicionador_pkg:
  - Channel state enum (ESPERA, FILTRA_PRESS, PRESSIONADO, FILTRA_SOLTA).
  - Direction codes CMD_NENHUM = 2'b00, CMD_POS = 2'b01, CMD_NEG = 2'b10.
- Sub-module botao_debounce: one channel = synchronizer + FSM + optional repeat.
  - Parameters: DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, REPEAT_ALLOWED.
  - Outputs: pulso, nivel.
  - Instantiated 5 times; confirma uses REPEAT_ALLOWED = 0.
- Top-level contents: instances, opposing-pulse cancellation, output registers.

Test Plan:
- Reset: reset = 0 with all buttons held 1 for 10 cycles -> all outputs 0; release reset with buttons held -> exactly one pulse per button after 2 + 4 cycles.
- Clean press: botao_frente = 1 for 20 cycles -> controle_horizontal = 01 for exactly 1 cycle, 6 cycles after the edge; no pulse on release.
- Bounce rejection: botao_cima toggled 1,0,1,0 with 1-cycle pulses, then held -> a single controle_vertical = 01 pulse only after 4 stable samples. Release bounce 0,1,0 -> no extra pulse.
- Opposing pulses: cima and baixo rise in the same cycle -> controle_vertical stays 00 throughout; db_estado_botoes[1:0] = 11.
- Confirm: botao_confirma held 1000 cycles -> exactly one confirma pulse, with or without the macro.
- Auto-repeat (macro defined): botao_tras held 600 cycles -> pulses at t = 6, 6+250, 6+350, 6+450, 6+550 cycles after the edge. Without the macro -> only the t = 6 pulse.
